radiant_aux_ctrl: RTL and testbench
===================================

// Module: radiant_aux_ctrl
// PURPOSE
// Framed, checksummed control front-end and monitor mux for the aux CPLD. Replaces the raw 8-bit
// CTRL_DATA shift-select, where any stray bit changes SEL or enables BIST, with sync-word framing.
// Adds a register file for SEL/BIST/scan, an auto-scan sequencer that steps the monitor mux across
// all NCHAN LABs, and a registered, polarity-corrected MONTIMING output. Sits between FPGA CTRL pins
// and the LAB4 WR/SS_INCR/MONTIMING logic.
// PARAMETERS
// NCHAN      12              number of LAB channels (2..16)
// SEL_W      4               width of channel select; 2**SEL_W >= NCHAN
// MT_INVERT  12'b010011100001 per-channel MONTIMING polarity flip (bit i flips MON_IN[i])
// SYNC       8'hA5           frame sync byte
// PRESC_W    8               dwell prescaler width; one dwell tick = 2**PRESC_W clocks
// PORTS
// CTRL_CLK     in   1        free-running control clock, all logic posedge
// CTRL_RST_N   in   1        asynchronous active-low reset
// CTRL_DATA    in   1        serial control bit, LSB first
// CTRL_VALID   in   1        qualifies CTRL_DATA; bit sampled only when high
// MON_IN       in   NCHAN    post-ILVDS MONTIMING per channel
// MON_OUT      out  1        selected, polarity-corrected monitor
// SEL          out  SEL_W    current channel select (drives WR tristate/SS mux)
// BIST         out  1        BIST enable
// ANALOG_SEL   out  3        WR code for selected LAB in BIST
// SCAN_ACTIVE  out  1        auto-scan running
// SCAN_DONE    out  1        1-cycle pulse at end of one-shot scan
// FRAME_ERR    out  1        1-cycle pulse on rejected frame
// LED          out  4        BIST ? {BIST,ANALOG_SEL} : SEL[3:0] (zero-extended)
// BEHAVIOUR
// Reset: all outputs 0; registers SEL=0, BIST=0, ANALOG_SEL=0, DWELL=0, scan off; FSM=HUNT.
// Frame: 24 bits LSB first: [7:0]=SYNC, [11:8]=ADDR, [19:12]=DATA, [23:20]=CSUM.
// CSUM = ADDR ^ DATA[3:0] ^ DATA[7:4].
// FSM (advances only on CTRL_VALID cycles):
//  - HUNT: 8-bit sliding window; window==SYNC -> BODY, bit counter=0.
//  - BODY: shift 16 bits; on 16th bit -> CHECK.
//  - CHECK: one cycle, no bit consumed. Bad CSUM or bad write -> FRAME_ERR, nothing changes.
//    Otherwise apply the write. Always -> HUNT with the window cleared.
// Register map (write-only):
//  - 0 SEL: DATA[SEL_W-1:0]. Value >= NCHAN is a bad write. A good write aborts any scan
//    (no SCAN_DONE).
//  - 1 BIST: DATA[7]->BIST, DATA[2:0]->ANALOG_SEL.
//  - 2 SCAN: DATA[0]=start, DATA[1]=continuous. Start: SEL=0, dwell counter=0, SCAN_ACTIVE=1.
//    DATA[0]=0 stops scan, SEL holds its value.
//  - 3 DWELL: DATA -> DWELL.
//  - 4..15: bad write (FRAME_ERR).
// Write effect visible on outputs the cycle after CHECK.
// Scan: channel held (DWELL+1)*2**PRESC_W cycles, then SEL+1.
//  - At SEL==NCHAN-1, continuous: wrap to 0.
//  - At SEL==NCHAN-1, one-shot: SEL stays, SCAN_ACTIVE->0, SCAN_DONE pulses that cycle.
//  - DWELL write during scan takes effect at the next channel step.
// MON_OUT <= MON_IN[SEL] ^ MT_INVERT[SEL]; 1-cycle latency from SEL/MON_IN change.
// CTRL_VALID low mid-frame pauses the FSM. There is no timeout; a lost frame is recovered by sync
// hunt. Reset mid-frame or mid-scan returns to reset state immediately.
// TESTING
// - Reset, frame ADDR0 DATA 0x07 CSUM 0x7 -> SEL=7 after CHECK, MON_OUT=MON_IN[7]^MT_INVERT[7]
//   1 cycle later; LED=4'h7.
// - Same frame with CSUM 0x6 -> FRAME_ERR 1-cycle pulse, SEL unchanged. Next good frame is accepted.
// - ADDR0 DATA 0x0C (NCHAN=12) -> FRAME_ERR, SEL unchanged; ADDR5 any -> FRAME_ERR.
// - DWELL=0, PRESC_W=2, SCAN one-shot -> SEL steps every 4 clocks 0..11. SCAN_DONE pulses once at
//   11; SCAN_ACTIVE=0; SEL stays 11.
// - Continuous scan: after channel 11 SEL wraps to 0. A SEL=3 write mid-scan -> SCAN_ACTIVE=0,
//   SEL=3, no SCAN_DONE.
// - Noise bits + CTRL_VALID gaps + frame; assert CTRL_RST_N low mid-frame -> all outputs 0,
//   FSM HUNT. A full frame after release is accepted.

Source files
------------

// File: rtl/radiant_aux_ctrl.sv
// Framed, checksummed serial control front-end for the aux CPLD: SEL/BIST/DWELL register file,
// auto-scan sequencer across the LAB channels and a registered, polarity-corrected monitor mux.
module radiant_aux_ctrl #(
  parameter int unsigned      NCHAN     = 12,
  parameter int unsigned      SEL_W     = 4,
  parameter logic [NCHAN-1:0] MT_INVERT = 12'b010011100001,
  parameter logic [7:0]       SYNC      = 8'hA5,
  parameter int unsigned      PRESC_W   = 8
) (
  input  logic             CTRL_CLK,
  input  logic             CTRL_RST_N,
  input  logic             CTRL_DATA,
  input  logic             CTRL_VALID,
  input  logic [NCHAN-1:0] MON_IN,
  output logic             MON_OUT,
  output logic [SEL_W-1:0] SEL,
  output logic             BIST,
  output logic [2:0]       ANALOG_SEL,
  output logic             SCAN_ACTIVE,
  output logic             SCAN_DONE,
  output logic             FRAME_ERR,
  output logic [3:0]       LED
);
  localparam int unsigned CntW = PRESC_W + 8;

  typedef enum logic [1:0] {StHunt, StBody, StCheck} state_e;

  state_e           state_q, state_d;
  logic [7:0]       win_q, win_d;
  logic [15:0]      body_q, body_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             bist_q, bist_d;
  logic [2:0]       asel_q, asel_d;
  logic [7:0]       dwell_q, dwell_d;
  logic [7:0]       dwell_cur_q, dwell_cur_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             scan_q, scan_d;
  logic             cont_q, cont_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             mon_q, mon_d;

  logic [3:0]       f_addr, f_csum;
  logic [7:0]       f_data;
  logic             csum_ok, wr_ok, step, last_ch;
  logic [NCHAN-1:0] mon_fix;

  // Body is shifted in LSB first, so the earliest body bit ends up at body_q[0].
  assign f_addr  = body_q[3:0];
  assign f_data  = body_q[11:4];
  assign f_csum  = body_q[15:12];
  assign csum_ok = (f_csum == (f_addr ^ f_data[3:0] ^ f_data[7:4]));
  assign mon_fix = MON_IN ^ MT_INVERT;
  // Dwell snapshot makes a mid-scan DWELL write apply only from the next channel step.
  assign step    = scan_q && (cnt_q == {dwell_cur_q, {PRESC_W{1'b1}}});
  assign last_ch = (sel_q == SEL_W'(NCHAN - 1));

  always_comb begin
    case (f_addr)
      4'd0:             wr_ok = (32'(f_data[SEL_W-1:0]) < NCHAN);
      4'd1, 4'd2, 4'd3: wr_ok = 1'b1;
      default:          wr_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    body_d      = body_q;
    bitcnt_d    = bitcnt_q;
    sel_d       = sel_q;
    bist_d      = bist_q;
    asel_d      = asel_q;
    dwell_d     = dwell_q;
    dwell_cur_d = dwell_cur_q;
    cnt_d       = cnt_q;
    scan_d      = scan_q;
    cont_d      = cont_q;
    done_d      = 1'b0;
    ferr_d      = 1'b0;
    mon_d       = mon_fix[sel_q];

    if (scan_q) begin
      if (step) begin
        cnt_d       = '0;
        dwell_cur_d = dwell_q;
        if (!last_ch) begin
          sel_d = sel_q + SEL_W'(1);
        end else if (cont_q) begin
          sel_d = '0;
        end else begin
          scan_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    unique case (state_q)
      StHunt: begin
        if (CTRL_VALID) begin
          win_d = {CTRL_DATA, win_q[7:1]};
          if ({CTRL_DATA, win_q[7:1]} == SYNC) begin
            state_d  = StBody;
            bitcnt_d = '0;
          end
        end
      end
      StBody: begin
        if (CTRL_VALID) begin
          body_d   = {CTRL_DATA, body_q[15:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd15) state_d = StCheck;
        end
      end
      StCheck: begin
        state_d = StHunt;
        win_d   = '0;
        if (!csum_ok || !wr_ok) begin
          ferr_d = 1'b1;
        end else begin
          // A register write takes priority over a scan step landing in the same cycle.
          case (f_addr)
            4'd0: begin
              sel_d  = f_data[SEL_W-1:0];
              scan_d = 1'b0;
              done_d = 1'b0;
            end
            4'd1: begin
              bist_d = f_data[7];
              asel_d = f_data[2:0];
            end
            4'd2: begin
              done_d = 1'b0;
              if (f_data[0]) begin
                sel_d       = '0;
                cnt_d       = '0;
                scan_d      = 1'b1;
                cont_d      = f_data[1];
                dwell_cur_d = dwell_q;
              end else begin
                sel_d  = sel_q;
                scan_d = 1'b0;
              end
            end
            4'd3: begin
              dwell_d = f_data;
              if (step) dwell_cur_d = f_data;
            end
            default: ;
          endcase
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge CTRL_CLK or negedge CTRL_RST_N) begin
    if (!CTRL_RST_N) begin
      state_q     <= StHunt;
      win_q       <= '0;
      body_q      <= '0;
      bitcnt_q    <= '0;
      sel_q       <= '0;
      bist_q      <= 1'b0;
      asel_q      <= '0;
      dwell_q     <= '0;
      dwell_cur_q <= '0;
      cnt_q       <= '0;
      scan_q      <= 1'b0;
      cont_q      <= 1'b0;
      done_q      <= 1'b0;
      ferr_q      <= 1'b0;
      mon_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      body_q      <= body_d;
      bitcnt_q    <= bitcnt_d;
      sel_q       <= sel_d;
      bist_q      <= bist_d;
      asel_q      <= asel_d;
      dwell_q     <= dwell_d;
      dwell_cur_q <= dwell_cur_d;
      cnt_q       <= cnt_d;
      scan_q      <= scan_d;
      cont_q      <= cont_d;
      done_q      <= done_d;
      ferr_q      <= ferr_d;
      mon_q       <= mon_d;
    end
  end

  assign MON_OUT     = mon_q;
  assign SEL         = sel_q;
  assign BIST        = bist_q;
  assign ANALOG_SEL  = asel_q;
  assign SCAN_ACTIVE = scan_q;
  assign SCAN_DONE   = done_q;
  assign FRAME_ERR   = ferr_q;
  assign LED         = bist_q ? {bist_q, asel_q} : 4'(sel_q);

endmodule

// File: tb/tb_radiant_aux_ctrl.sv
// Scoreboard bench for radiant_aux_ctrl: directed frames push expected output events into a
// queue; a negedge monitor pops and compares whenever SEL/BIST/scan state changes or a pulse fires.
module tb_radiant_aux_ctrl;
  localparam logic [11:0] MtInv = 12'b010011100001;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        ctrl_data  = 1'b0;
  logic        ctrl_valid = 1'b0;
  logic [11:0] mon_in     = '0;
  logic        mon_out;
  logic [3:0]  sel;
  logic        bist;
  logic [2:0]  asel;
  logic        scan_active;
  logic        scan_done;
  logic        frame_err;
  logic [3:0]  led;

  typedef struct packed {
    logic [3:0] sel;
    logic       bist;
    logic [2:0] asel;
    logic       act;
    logic       done;
    logic       ferr;
    logic [3:0] led;
    logic [7:0] delta;  // cycles since previous event, 0 = don't care
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  radiant_aux_ctrl #(
    .NCHAN    (12),
    .SEL_W    (4),
    .MT_INVERT(MtInv),
    .SYNC     (8'hA5),
    .PRESC_W  (2)
  ) dut (
    .CTRL_CLK   (clk),
    .CTRL_RST_N (rst_n),
    .CTRL_DATA  (ctrl_data),
    .CTRL_VALID (ctrl_valid),
    .MON_IN     (mon_in),
    .MON_OUT    (mon_out),
    .SEL        (sel),
    .BIST       (bist),
    .ANALOG_SEL (asel),
    .SCAN_ACTIVE(scan_active),
    .SCAN_DONE  (scan_done),
    .FRAME_ERR  (frame_err),
    .LED        (led)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_sel"}, 32'(sel), 32'd0);
    check({tag, "_bist"}, 32'(bist), 32'd0);
    check({tag, "_asel"}, 32'(asel), 32'd0);
    check({tag, "_scan_active"}, 32'(scan_active), 32'd0);
    check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_mon_out"}, 32'(mon_out), 32'd0);
  endtask

  function automatic ev_t mk_ev(input logic [3:0] s, input logic b, input logic [2:0] a,
                                input logic ac, input logic dn, input logic fe,
                                input logic [7:0] d);
    ev_t e;
    e.sel   = s;
    e.bist  = b;
    e.asel  = a;
    e.act   = ac;
    e.done  = dn;
    e.ferr  = fe;
    e.led   = b ? {b, a} : s;
    e.delta = d;
    return e;
  endfunction

  function automatic logic [23:0] frame(input logic [3:0] addr, input logic [7:0] data,
                                        input logic [3:0] csum);
    return {csum, data, addr, 8'hA5};
  endfunction

  // Sends the first n bits of f LSB first; with gaps, a CTRL_VALID-low cycle carrying the
  // inverted bit is inserted before every fifth bit.
  task automatic send_bits(input logic [23:0] f, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 5 == 2)) begin
        @(posedge clk); #1;
        ctrl_valid = 1'b0;
        ctrl_data  = ~f[i];
      end
      @(posedge clk); #1;
      ctrl_data  = f[i];
      ctrl_valid = 1'b1;
    end
    @(posedge clk); #1;
    ctrl_valid = 1'b0;
    ctrl_data  = 1'b0;
  endtask

  // Monitor: MON_OUT against the previous cycle's SEL/MON_IN, and output events against queue.
  initial begin
    logic [8:0]  prev_obs;
    logic [8:0]  obs;
    logic [11:0] prev_mon;
    logic [3:0]  prev_sel;
    bit          prev_ok;
    int          cyc;
    int          last_ev;
    ev_t         got;
    ev_t         want;
    prev_obs = '0;
    prev_mon = '0;
    prev_sel = '0;
    prev_ok  = 1'b0;
    cyc      = 0;
    last_ev  = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_obs = '0;
        prev_ok  = 1'b0;
        last_ev  = cyc;
      end else begin
        if (prev_ok) begin
          check("mon_out", 32'(mon_out), 32'(prev_mon[prev_sel] ^ MtInv[prev_sel]));
        end
        prev_mon = mon_in;
        prev_sel = sel;
        prev_ok  = 1'b1;
        obs = {sel, bist, asel, scan_active};
        if (obs != prev_obs || scan_done || frame_err) begin
          got.sel   = sel;
          got.bist  = bist;
          got.asel  = asel;
          got.act   = scan_active;
          got.done  = scan_done;
          got.ferr  = frame_err;
          got.led   = led;
          got.delta = (cyc - last_ev > 255) ? 8'd255 : 8'(cyc - last_ev);
          last_ev   = cyc;
          prev_obs  = obs;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %h expected none", got);
          end else begin
            want = exp_q.pop_front();
            if (want.delta == 8'd0) got.delta = 8'd0;
            check("event", 32'(got), 32'(want));
          end
        end
      end
    end
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // SEL=7, then MON_OUT polarity on channel 7 (MT_INVERT[7]=1).
    exp_q.push_back(mk_ev(4'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0));
    send_bits(frame(4'd0, 8'h07, 4'h7), 24, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("led_sel7", 32'(led), 32'h7);
    check("mon_sel7_in0", 32'(mon_out), 32'd1);
    mon_in = 12'h080;
    repeat (2) @(posedge clk);
    #1;
    check("mon_sel7_in1", 32'(mon_out), 32'd0);

    // Bad checksum, then a back-to-back good frame; bad SEL value, bad addresses.
    exp_q.push_back(mk_ev(4'd7, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0));
    send_bits(frame(4'd0, 8'h07, 4'h6), 24, 1'b0);
    exp_q.push_back(mk_ev(4'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0));
    send_bits(frame(4'd0, 8'h02, 4'h2), 24, 1'b0);
    exp_q.push_back(mk_ev(4'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0));
    send_bits(frame(4'd0, 8'h0C, 4'hC), 24, 1'b0);
    exp_q.push_back(mk_ev(4'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0));
    send_bits(frame(4'd5, 8'h00, 4'h5), 24, 1'b0);
    exp_q.push_back(mk_ev(4'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'd0));
    send_bits(frame(4'd4, 8'h00, 4'h4), 24, 1'b0);

    // BIST on with ANALOG_SEL=5 (LED=4'hD), then off again.
    exp_q.push_back(mk_ev(4'd2, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0));
    send_bits(frame(4'd1, 8'h85, 4'hC), 24, 1'b0);
    exp_q.push_back(mk_ev(4'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0));
    send_bits(frame(4'd1, 8'h00, 4'h1), 24, 1'b0);
    repeat (4) @(posedge clk);

    // One-shot scan, DWELL=0: 4 clocks per channel, SCAN_DONE once at channel 11.
    mon_in = '0;
    exp_q.push_back(mk_ev(4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0));
    for (int n = 1; n < 12; n++) exp_q.push_back(mk_ev(4'(n), 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd4));
    exp_q.push_back(mk_ev(4'd11, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd4));
    send_bits(frame(4'd2, 8'h01, 4'h3), 24, 1'b0);
    repeat (60) @(posedge clk);
    #1;
    check("oneshot_sel", 32'(sel), 32'd11);
    check("oneshot_active", 32'(scan_active), 32'd0);

    // One-shot scan, DWELL=1: 8 clocks per channel.
    send_bits(frame(4'd3, 8'h01, 4'h2), 24, 1'b0);
    exp_q.push_back(mk_ev(4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0));
    for (int n = 1; n < 12; n++) exp_q.push_back(mk_ev(4'(n), 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd8));
    exp_q.push_back(mk_ev(4'd11, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 8'd8));
    send_bits(frame(4'd2, 8'h01, 4'h3), 24, 1'b0);
    repeat (110) @(posedge clk);

    // Continuous scan, DWELL=0: wraps after 11; SEL=3 write lands while on channel 4.
    send_bits(frame(4'd3, 8'h00, 4'h3), 24, 1'b0);
    mon_in = 12'hFFF;
    exp_q.push_back(mk_ev(4'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0));
    for (int n = 1; n < 12; n++) exp_q.push_back(mk_ev(4'(n), 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd4));
    for (int n = 0; n < 5; n++) exp_q.push_back(mk_ev(4'(n), 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd4));
    exp_q.push_back(mk_ev(4'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0));
    send_bits(frame(4'd2, 8'h03, 4'h1), 24, 1'b0);
    repeat (40) @(posedge clk);
    send_bits(frame(4'd0, 8'h03, 4'h3), 24, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("abort_sel", 32'(sel), 32'd3);
    check("abort_active", 32'(scan_active), 32'd0);

    // Noise and CTRL_VALID gaps around a frame, then reset in the middle of a frame.
    mon_in = 12'h5A3;
    exp_q.push_back(mk_ev(4'd9, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0));
    send_bits(24'hCCCCCC, 24, 1'b1);
    send_bits(frame(4'd0, 8'h09, 4'h9), 24, 1'b1);
    repeat (4) @(posedge clk);
    send_bits(24'hCCCCCC, 12, 1'b1);
    send_bits(frame(4'd0, 8'h04, 4'h4), 14, 1'b1);
    rst_n = 1'b0;
    #2;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(mk_ev(4'd5, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0));
    send_bits(frame(4'd0, 8'h05, 4'h5), 24, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
